dest_reg_tracker: RTL



---
 rtl/mips_pipe_pkg.sv | 26 ++
 rtl/dest_stage.sv | 46 ++++
 rtl/dest_reg_tracker.sv | 119 +++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline constants for the MIPS core: destination select codes,
// Tnew/Tuse values and stage indices used by hazard tracking.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RT   = 2'd1,
    SEL_RD   = 2'd2,
    SEL_RA   = 2'd3
  } destSel_e;

  localparam int TNEW_ALU    = 1;
  localparam int TNEW_LOAD   = 2;
  localparam int TUSE_BRANCH = 0;
  localparam int TUSE_ALU    = 1;

  localparam int STAGE_E = 1;
  localparam int STAGE_M = 2;
  localparam int STAGE_W = 3;

  // Width of a stage index that also needs a "register file" code of 0.
  function automatic int fwdSelWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dest_stage.sv
// One tracked pipeline stage: a {addr, tnew} register with freeze, bubble
// insertion and an optional saturating Tnew decrement on advance.
module dest_stage
  import mips_pipe_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TW      = 2,
  parameter bit SAT_DEC = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              bubble,
  input  logic [ADDR_W-1:0] inAddr,
  input  logic [TW-1:0]     inTnew,
  output logic [ADDR_W-1:0] addr,
  output logic [TW-1:0]     tnew
);

  logic [TW-1:0] nextTnew;

  // Stage 1 takes decode's Tnew as-is; later stages count down toward 0.
  always_comb begin
    nextTnew = inTnew;
    if (SAT_DEC && inTnew != '0) begin
      nextTnew = inTnew - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr <= '0;
      tnew <= '0;
    end else if (hold) begin
      addr <= addr;
      tnew <= tnew;
    end else if (bubble) begin
      addr <= '0;
      tnew <= '0;
    end else begin
      addr <= inAddr;
      tnew <= nextTnew;
    end
  end

endmodule

// File: rtl/dest_reg_tracker.sv
// Destination-register tracker: picks the write-back address at decode, carries
// {addr, tnew} through DEPTH stages, and derives decode stall and forwarding selects.
module dest_reg_tracker
  import mips_pipe_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = int'(SEL_RA),
  parameter int SEL_W   = $clog2(NUM_SRC + 1),
  parameter int DEPTH   = STAGE_W,
  parameter int TW      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SEL_W-1:0]            sel,
  input  logic [NUM_SRC*ADDR_W-1:0]   cand,
  input  logic [TW-1:0]               tnew_in,
  input  logic [ADDR_W-1:0]           rs_addr,
  input  logic [ADDR_W-1:0]           rt_addr,
  input  logic [TW-1:0]               rs_tuse,
  input  logic [TW-1:0]               rt_tuse,
  input  logic                        flush,
  input  logic                        hold,
  output logic [ADDR_W-1:0]           dest_addr,
  output logic [DEPTH*ADDR_W-1:0]     stage_addr,
  output logic [ADDR_W-1:0]           w_addr,
  output logic                        stall,
  output logic [$clog2(DEPTH+1)-1:0]  fwd_rs_sel,
  output logic [$clog2(DEPTH+1)-1:0]  fwd_rt_sel
);

  localparam int FW = fwdSelWidth(DEPTH);

  logic [ADDR_W-1:0] candArr   [1:NUM_SRC];
  logic [ADDR_W-1:0] stageAddr [1:DEPTH];
  logic [TW-1:0]     stageTnew [1:DEPTH];
  logic              bubble;

  logic              rsHit, rtHit;
  logic [TW-1:0]     rsTnew, rtTnew;
  logic [FW-1:0]     rsStage, rtStage;

  genvar gi;

  generate
    for (gi = 1; gi <= NUM_SRC; gi++) begin : gCand
      assign candArr[gi] = cand[gi*ADDR_W-1 -: ADDR_W];
    end
  endgenerate

  always_comb begin
    dest_addr = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        dest_addr = candArr[i];
      end
    end
  end

  assign bubble = stall | flush;

  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : gStage
      if (gi == 1) begin : gFirst
        dest_stage #(.ADDR_W(ADDR_W), .TW(TW), .SAT_DEC(1'b0)) uStage (
          .clk    (clk),
          .reset  (reset),
          .hold   (hold),
          .bubble (bubble),
          .inAddr (dest_addr),
          .inTnew (tnew_in),
          .addr   (stageAddr[gi]),
          .tnew   (stageTnew[gi])
        );
      end else begin : gLater
        dest_stage #(.ADDR_W(ADDR_W), .TW(TW), .SAT_DEC(1'b1)) uStage (
          .clk    (clk),
          .reset  (reset),
          .hold   (hold),
          .bubble (1'b0),
          .inAddr (stageAddr[gi-1]),
          .inTnew (stageTnew[gi-1]),
          .addr   (stageAddr[gi]),
          .tnew   (stageTnew[gi])
        );
      end
      assign stage_addr[gi*ADDR_W-1 -: ADDR_W] = stageAddr[gi];
    end
  endgenerate

  assign w_addr = stageAddr[DEPTH];

  // Scan from the oldest stage toward stage 1 so the nearest producer wins.
  always_comb begin
    rsHit   = 1'b0;
    rsTnew  = '0;
    rsStage = '0;
    rtHit   = 1'b0;
    rtTnew  = '0;
    rtStage = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (rs_addr != '0 && stageAddr[k] == rs_addr) begin
        rsHit   = 1'b1;
        rsTnew  = stageTnew[k];
        rsStage = FW'(k);
      end
      if (rt_addr != '0 && stageAddr[k] == rt_addr) begin
        rtHit   = 1'b1;
        rtTnew  = stageTnew[k];
        rtStage = FW'(k);
      end
    end
  end

  assign stall = (rsHit && (rsTnew > rs_tuse)) || (rtHit && (rtTnew > rt_tuse));

  assign fwd_rs_sel = (rsHit && rsTnew == '0) ? rsStage : '0;
  assign fwd_rt_sel = (rtHit && rtTnew == '0) ? rtStage : '0;

endmodule
